// File: rtl/sync_fifo_prog_if.sv
// rtl/sync_fifo_prog_if.sv - write/read handshake, threshold and status bundle for sync_fifo_prog
interface sync_fifo_prog_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              winc;
  logic [DATA_W-1:0] wdata;
  logic              rinc;
  logic [ADDR_W:0]   af_thresh;
  logic [ADDR_W:0]   ae_thresh;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wfull;
  logic              wfull_almost;
  logic              rempty;
  logic              rempty_almost;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, winc, wdata, rinc, af_thresh, ae_thresh,
    input  rdata, rvalid, wfull, wfull_almost, rempty, rempty_almost, level, overflow, underflow
  );

  modport slave (
    input  clr, winc, wdata, rinc, af_thresh, ae_thresh,
    output rdata, rvalid, wfull, wfull_almost, rempty, rempty_almost, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO with programmable thresholds, sticky errors, flush, FWFT option
module sync_fifo_prog #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter bit FWFT   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_prog_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   fill;
  logic              full;
  logic              empty;
  logic              wen;
  logic              ren;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ovf_q;
  logic              unf_q;

  // Status derives from registered pointers only, so flags never combinationally follow winc/rinc.
  assign fill  = wptr - rptr;
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign empty = (wptr == rptr);
  assign wen   = bus.winc & ~full;
  assign ren   = bus.rinc & ~empty;

  assign bus.level         = fill;
  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.wfull_almost  = (fill >= bus.af_thresh);
  assign bus.rempty_almost = (fill <= bus.ae_thresh);
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = unf_q;

  always_ff @(posedge clk) begin
    if (wen && !bus.clr) begin
      mem[wptr[ADDR_W-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.clr) begin
      wptr     <= '0;
      rptr     <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wen) begin
        wptr <= wptr + 1'b1;
      end
      if (ren) begin
        rptr    <= rptr + 1'b1;
        rdata_q <= mem[rptr[ADDR_W-1:0]];
      end
      rvalid_q <= ren;
      if (bus.winc && full) begin
        ovf_q <= 1'b1;
      end
      if (bus.rinc && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  // In FWFT mode the head word is shown directly; rdata_q keeps the last popped word for the empty case.
  if (FWFT) begin : g_fwft
    assign bus.rdata  = empty ? rdata_q : mem[rptr[ADDR_W-1:0]];
    assign bus.rvalid = ~empty;
  end else begin : g_std
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - directed self-checking bench for sync_fifo_prog in standard and FWFT modes
module tb_sync_fifo_prog;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  sync_fifo_prog_if #(.DATA_W(8), .ADDR_W(4)) if_std ();
  sync_fifo_prog_if #(.DATA_W(8), .ADDR_W(4)) if_fw ();

  sync_fifo_prog #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b0)) u_std (.clk(clk), .rst_n(rst_n), .bus(if_std));
  sync_fifo_prog #(.DATA_W(8), .ADDR_W(4), .FWFT(1'b1)) u_fw  (.clk(clk), .rst_n(rst_n), .bus(if_fw));

  typedef struct {
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [4:0] level;
    logic       wfull;
    logic       wfa;
    logic       rempty;
    logic       rea;
    logic       rvalid;
    logic [7:0] rdata;
    logic       chk_rd;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t       vt[34];
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] last_d;
  int         pulses;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    {if_std.clr, if_std.winc, if_std.rinc, if_std.wdata} = '0;
    {if_fw.clr, if_fw.winc, if_fw.rinc, if_fw.wdata} = '0;
    if_std.af_thresh = 5'd14;
    if_std.ae_thresh = 5'd2;
    if_fw.af_thresh  = 5'd14;
    if_fw.ae_thresh  = 5'd2;

    // Fill 0x00..0x0F, one ignored 17th write, then drain 16 words plus one read on empty.
    for (int i = 0; i < 16; i++)
      vt[i] = '{1'b1, 8'(i), 1'b0, 5'(i + 1), (i == 15), (i >= 13), 1'b0, (i <= 1), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b1, 8'hEE, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 16; j++)
      vt[17 + j] = '{1'b0, 8'h00, 1'b1, 5'(15 - j), 1'b0, (j <= 1), (j == 15), (j >= 13), 1'b1, 8'(j), 1'b1, 1'b1, 1'b0};
    vt[33] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b1};

    #2;
    chk("rst_level", 32'(if_std.level), 32'd0);
    chk("rst_rempty", 32'(if_std.rempty), 32'd1);
    chk("rst_rea", 32'(if_std.rempty_almost), 32'd1);
    chk("rst_wfull", 32'(if_std.wfull), 32'd0);
    chk("rst_rvalid", 32'(if_std.rvalid), 32'd0);
    chk("rst_rdata", 32'(if_std.rdata), 32'd0);
    chk("rst_ovf_unf", 32'({if_std.overflow, if_std.underflow}), 32'd0);
    #10 rst_n = 1'b1;

    pulses = 0;
    for (int i = 0; i < 34; i++) begin
      if_std.winc  = vt[i].winc;
      if_std.wdata = vt[i].wdata;
      if_std.rinc  = vt[i].rinc;
      step();
      chk($sformatf("v%0d_level", i), 32'(if_std.level), 32'(vt[i].level));
      chk($sformatf("v%0d_wfull", i), 32'(if_std.wfull), 32'(vt[i].wfull));
      chk($sformatf("v%0d_wfa", i), 32'(if_std.wfull_almost), 32'(vt[i].wfa));
      chk($sformatf("v%0d_rempty", i), 32'(if_std.rempty), 32'(vt[i].rempty));
      chk($sformatf("v%0d_rea", i), 32'(if_std.rempty_almost), 32'(vt[i].rea));
      chk($sformatf("v%0d_rvalid", i), 32'(if_std.rvalid), 32'(vt[i].rvalid));
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), 32'(if_std.rdata), 32'(vt[i].rdata));
      chk($sformatf("v%0d_ovf", i), 32'(if_std.overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(if_std.underflow), 32'(vt[i].unf));
      if (i >= 17 && if_std.rvalid) pulses++;
    end
    chk("drain_pulses", 32'(pulses), 32'd16);
    if_std.rinc = 1'b0;

    if_std.clr = 1'b1;
    step();
    if_std.clr = 1'b0;
    chk("clr_level", 32'(if_std.level), 32'd0);
    chk("clr_flags", 32'({if_std.overflow, if_std.underflow}), 32'd0);

    // Simultaneous read/write at level 5 for 40 cycles: pointers wrap, level constant.
    for (int k = 0; k < 5; k++) begin
      if_std.winc  = 1'b1;
      if_std.wdata = 8'h10 + 8'(k);
      q.push_back(if_std.wdata);
      step();
    end
    chk("wrap_start_level", 32'(if_std.level), 32'd5);
    for (int k = 0; k < 40; k++) begin
      if_std.winc  = 1'b1;
      if_std.rinc  = 1'b1;
      if_std.wdata = 8'h40 + 8'(k);
      exp_d = q.pop_front();
      q.push_back(if_std.wdata);
      step();
      chk($sformatf("wrap%0d_rdata", k), 32'(if_std.rdata), 32'(exp_d));
      chk($sformatf("wrap%0d_level", k), 32'(if_std.level), 32'd5);
      chk($sformatf("wrap%0d_rvalid", k), 32'(if_std.rvalid), 32'd1);
    end
    chk("wrap_flags", 32'({if_std.overflow, if_std.underflow}), 32'd0);
    if_std.rinc = 1'b0;

    // Build level 9 with overflow set, then flush with a concurrent write.
    for (int k = 0; k < 11; k++) begin
      if_std.wdata = 8'h80 + 8'(k);
      q.push_back(if_std.wdata);
      step();
    end
    chk("refill_wfull", 32'(if_std.wfull), 32'd1);
    if_std.wdata = 8'hFF;
    step();
    chk("refill_ovf", 32'(if_std.overflow), 32'd1);
    chk("refill_level", 32'(if_std.level), 32'd16);
    if_std.winc = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if_std.rinc = 1'b1;
      exp_d = q.pop_front();
      step();
      chk($sformatf("pop%0d_rdata", k), 32'(if_std.rdata), 32'(exp_d));
    end
    last_d = exp_d;
    chk("pre_flush_level", 32'(if_std.level), 32'd9);
    if_std.rinc  = 1'b0;
    if_std.clr   = 1'b1;
    if_std.winc  = 1'b1;
    if_std.wdata = 8'h77;
    step();
    if_std.clr  = 1'b0;
    if_std.winc = 1'b0;
    chk("flush_level", 32'(if_std.level), 32'd0);
    chk("flush_rempty", 32'(if_std.rempty), 32'd1);
    chk("flush_ovf", 32'(if_std.overflow), 32'd0);
    chk("flush_rvalid", 32'(if_std.rvalid), 32'd0);
    chk("flush_rdata_kept", 32'(if_std.rdata), 32'(last_d));
    if_std.rinc = 1'b1;
    step();
    if_std.rinc = 1'b0;
    chk("flush_discard_unf", 32'(if_std.underflow), 32'd1);
    chk("flush_discard_rvalid", 32'(if_std.rvalid), 32'd0);
    q.delete();

    // Threshold edges take effect without a clock edge.
    if_std.af_thresh = 5'd0;
    #1 chk("af0_forces", 32'(if_std.wfull_almost), 32'd1);
    if_std.af_thresh = 5'd14;
    #1 chk("af14_empty", 32'(if_std.wfull_almost), 32'd0);
    if_std.winc  = 1'b1;
    if_std.wdata = 8'h01;
    step();
    if_std.ae_thresh = 5'd0;
    #1 chk("ae0_level1", 32'(if_std.rempty_almost), 32'd0);
    if_std.ae_thresh = 5'd16;
    #1 chk("ae16_forces", 32'(if_std.rempty_almost), 32'd1);
    if_std.ae_thresh = 5'd2;

    // Burst to level 7, then asynchronous reset between edges.
    for (int k = 0; k < 6; k++) step();
    if_std.rinc = 1'b1;
    step();
    chk("burst_level", 32'(if_std.level), 32'd7);
    chk("burst_rvalid", 32'(if_std.rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(if_std.level), 32'd0);
    chk("arst_rempty", 32'(if_std.rempty), 32'd1);
    chk("arst_rvalid", 32'(if_std.rvalid), 32'd0);
    chk("arst_unf", 32'(if_std.underflow), 32'd0);
    if_std.winc = 1'b0;
    if_std.rinc = 1'b0;
    #3 rst_n = 1'b1;

    // FWFT instance.
    step();
    chk("fw_rst_rempty", 32'(if_fw.rempty), 32'd1);
    chk("fw_rst_rvalid", 32'(if_fw.rvalid), 32'd0);
    chk("fw_rst_rdata", 32'(if_fw.rdata), 32'd0);
    if_fw.winc  = 1'b1;
    if_fw.wdata = 8'hA5;
    step();
    if_fw.winc = 1'b0;
    chk("fw_rdata", 32'(if_fw.rdata), 32'hA5);
    chk("fw_rvalid", 32'(if_fw.rvalid), 32'd1);
    chk("fw_rempty", 32'(if_fw.rempty), 32'd0);
    chk("fw_level", 32'(if_fw.level), 32'd1);
    if_fw.rinc = 1'b1;
    step();
    if_fw.rinc = 1'b0;
    chk("fw_pop_rempty", 32'(if_fw.rempty), 32'd1);
    chk("fw_pop_rvalid", 32'(if_fw.rvalid), 32'd0);
    if_fw.winc  = 1'b1;
    if_fw.wdata = 8'h11;
    step();
    if_fw.wdata = 8'h22;
    step();
    if_fw.winc = 1'b0;
    chk("fw_head1", 32'(if_fw.rdata), 32'h11);
    if_fw.rinc = 1'b1;
    step();
    if_fw.rinc = 1'b0;
    chk("fw_head2", 32'(if_fw.rdata), 32'h22);
    chk("fw_head2_rvalid", 32'(if_fw.rvalid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
